// File: rtl/ppm_pkg.sv
// Shared types and constants for the PPM modulator.
package ppm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_GUARD = 2'd2
  } state_t;

  localparam logic MODE_PPM  = 1'b0;
  localparam logic MODE_DPPM = 1'b1;

  localparam int unsigned GUARD_W = 4;

  // Counter width for a modulus of n, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ppm_slot_timer.sv
// Cycle-within-slot counter; flags the last cycle of every slot.
module ppm_slot_timer
  import ppm_pkg::*;
#(
  parameter int unsigned SLOT_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic clear,
  output logic slot_last
);

  localparam int unsigned          CYC_W    = cnt_width(SLOT_CYC);
  localparam logic [CYC_W-1:0]     CYC_LAST = CYC_W'(SLOT_CYC - 1);

  logic [CYC_W-1:0] cyc_q;

  // Count 0..SLOT_CYC-1 while enabled; clear holds the count at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_q <= '0;
    end else if (ena) begin
      if (clear || (cyc_q == CYC_LAST)) begin
        cyc_q <= '0;
      end else begin
        cyc_q <= cyc_q + CYC_W'(1);
      end
    end
  end

  assign slot_last = (cyc_q == CYC_LAST);

endmodule

// File: rtl/ppm_modulator.sv
// Pulse-position modulator with fixed-frame PPM and differential PPM modes.
module ppm_modulator
  import ppm_pkg::*;
#(
  parameter int unsigned SYM_W       = 3,
  parameter int unsigned SLOT_CYC    = 4,
  parameter int unsigned GUARD_SLOTS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [SYM_W-1:0] sym_data,
  input  logic             sym_valid,
  output logic             sym_ready,
  input  logic             mode,
  output logic             ppm_out,
  output logic             frame_start,
  output logic             busy
);

  localparam logic [SYM_W-1:0]   SLOT_MAX   = SYM_W'((1 << SYM_W) - 1);
  localparam logic [GUARD_W-1:0] GUARD_LAST = (GUARD_SLOTS == 0) ? '0 : GUARD_W'(GUARD_SLOTS - 1);
  localparam bit                 HAS_GUARD  = (GUARD_SLOTS != 0);

  state_t             state_q, state_d;
  logic [SYM_W-1:0]   slot_q, slot_d;
  logic [GUARD_W-1:0] guard_q, guard_d;
  logic [SYM_W-1:0]   sym_q, sym_d;
  logic               mode_q, mode_d;
  logic               pulse_q, pulse_d;
  logic               start_q, start_d;
  logic               busy_q, busy_d;

  logic               slot_last;
  logic [SYM_W-1:0]   end_slot;
  logic               frame_last;
  logic               guard_last;
  logic               last_cycle;
  logic               ready_c;
  logic               accept;

  // Slot timing runs only while a frame or guard interval is active.
  ppm_slot_timer #(
    .SLOT_CYC (SLOT_CYC)
  ) u_slot_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .clear     (state_q == ST_IDLE),
    .slot_last (slot_last)
  );

  // DPPM frames stop at the pulse slot; PPM frames always run every slot.
  assign end_slot   = (mode_q == MODE_DPPM) ? sym_q : SLOT_MAX;
  assign frame_last = (state_q == ST_FRAME) && (slot_q == end_slot) && slot_last;
  assign guard_last = (state_q == ST_GUARD) && (guard_q == GUARD_LAST) && slot_last;
  assign last_cycle = HAS_GUARD ? guard_last : frame_last;
  assign ready_c    = ena && rst_n && ((state_q == ST_IDLE) || last_cycle);
  assign accept     = sym_valid && ready_c;

  // Next-state and registered-output decode; everything holds when ena is low.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    guard_d = guard_q;
    sym_d   = sym_q;
    mode_d  = mode_q;
    start_d = start_q;
    if (ena) begin
      start_d = 1'b0;
      if (accept) begin
        state_d = ST_FRAME;
        slot_d  = '0;
        guard_d = '0;
        sym_d   = sym_data;
        mode_d  = mode;
        start_d = 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            slot_d  = '0;
            guard_d = '0;
          end
          ST_FRAME: begin
            if (slot_last) begin
              if (slot_q == end_slot) begin
                slot_d  = '0;
                guard_d = '0;
                state_d = HAS_GUARD ? ST_GUARD : ST_IDLE;
              end else begin
                slot_d = slot_q + SYM_W'(1);
              end
            end
          end
          ST_GUARD: begin
            if (slot_last) begin
              if (guard_q == GUARD_LAST) begin
                guard_d = '0;
                state_d = ST_IDLE;
              end else begin
                guard_d = guard_q + GUARD_W'(1);
              end
            end
          end
          default: begin
            state_d = ST_IDLE;
          end
        endcase
      end
    end
    pulse_d = (state_d == ST_FRAME) && (slot_d == sym_d);
    busy_d  = (state_d != ST_IDLE);
  end

  // State, counters, symbol latch and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      slot_q  <= '0;
      guard_q <= '0;
      sym_q   <= '0;
      mode_q  <= MODE_PPM;
      pulse_q <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      guard_q <= guard_d;
      sym_q   <= sym_d;
      mode_q  <= mode_d;
      pulse_q <= pulse_d;
      start_q <= start_d;
      busy_q  <= busy_d;
    end
  end

  assign ppm_out     = pulse_q && ena;
  assign frame_start = start_q && ena;
  assign busy        = busy_q;
  assign sym_ready   = ready_c;

endmodule
